// File: rtl/clk_div_sel.sv
// clk_div_sel: CPU clock generator with three free-running rates and a
// push-button single-step mode; mode changes land on period boundaries.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   mode_sel[1:0] requested mode: 00 fast, 01 mid, 10 slow, 11 step
//   step          debounced step button (level; rising edge used)
//   Clk_CPU       registered 50% divided clock
//   clk_en        one-cycle strobe on each Clk_CPU rising edge
//   mode_act[1:0] mode currently applied
//   cyc_cnt[31:0] Clk_CPU rising-edge count when CLK_DIV_CYC_CNT_EN
//                 is defined, otherwise tied to zero
module clk_div_sel #(
  parameter int CNT_W     = 26,
  parameter int HALF_FAST = 4,
  parameter int HALF_MID  = 1048576,
  parameter int HALF_SLOW = 33554432,
  parameter int HALF_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_sel,
  input  logic        step,
  output logic        Clk_CPU,
  output logic        clk_en,
  output logic [1:0]  mode_act,
  output logic [31:0] cyc_cnt
);

  typedef enum logic [1:0] {
    RUN,
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] FAST_M1 =
    CNT_W'(HALF_FAST - 1);
  localparam logic [CNT_W-1:0] MID_M1 =
    CNT_W'(HALF_MID - 1);
  localparam logic [CNT_W-1:0] SLOW_M1 =
    CNT_W'(HALF_SLOW - 1);
  localparam logic [CNT_W-1:0] STEP_M1 =
    CNT_W'(HALF_STEP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_m1;
  logic             step_q;
  logic             step_rise;
  logic             run_end;
  logic             step_end;

  // Mode 11 never counts in RUN (it is left at the same
  // boundary it is applied), so its entry is a don't-care.
  always_comb begin
    half_m1 = MID_M1;
    unique case (mode_act)
      2'b00:   half_m1 = FAST_M1;
      2'b01:   half_m1 = MID_M1;
      2'b10:   half_m1 = SLOW_M1;
      default: half_m1 = MID_M1;
    endcase
  end

  assign step_rise = step & ~step_q;
  assign run_end   = (cnt == half_m1);
  assign step_end  = (cnt == STEP_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      step_q   <= 1'b0;
      Clk_CPU  <= 1'b0;
      clk_en   <= 1'b0;
      mode_act <= 2'b00;
    end else begin
      step_q <= step;
      clk_en <= 1'b0;
      unique case (state)
        RUN: begin
          if (run_end) begin
            cnt     <= '0;
            Clk_CPU <= ~Clk_CPU;
            clk_en  <= ~Clk_CPU;
            // Falling edge closes the high phase: only here
            // may a new mode take over.
            if (Clk_CPU) begin
              mode_act <= mode_sel;
              if (mode_sel == 2'b11) begin
                state <= IDLE;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE: begin
          Clk_CPU <= 1'b0;
          cnt     <= '0;
          if (mode_sel != 2'b11) begin
            state    <= RUN;
            mode_act <= mode_sel;
          end else if (step_rise) begin
            state   <= HIGH;
            Clk_CPU <= 1'b1;
            clk_en  <= 1'b1;
          end
        end
        HIGH: begin
          if (step_end) begin
            cnt     <= '0;
            Clk_CPU <= 1'b0;
            state   <= LOW;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOW: begin
          if (step_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef CLK_DIV_CYC_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (clk_en) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`else
  assign cyc_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_clk_div_sel.sv
// tb_clk_div_sel: directed bench for clk_div_sel; expected clk_en
// events are queued by stimulus and matched by a separate monitor.
module tb_clk_div_sel;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    int         high;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_sel = 2'b00;
  logic        step = 1'b0;
  logic        Clk_CPU;
  logic        clk_en;
  logic [1:0]  mode_act;
  logic [31:0] cyc_cnt;

  int   ecnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  clk_div_sel #(
    .CNT_W    (4),
    .HALF_FAST(2),
    .HALF_MID (3),
    .HALF_SLOW(5),
    .HALF_STEP(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode_sel(mode_sel),
    .step    (step),
    .Clk_CPU (Clk_CPU),
    .clk_en  (clk_en),
    .mode_act(mode_act),
    .cyc_cnt (cyc_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic wait_edge(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  task automatic push(input int c,
                      input logic [1:0] m,
                      input int h);
    exp_t e;
    e.cyc  = c;
    e.mode = m;
    e.high = h;
    sbq.push_back(e);
  endtask

  // Monitor: matches each clk_en against the queue and
  // measures the following high phase.
  int   hcnt = 0;
  int   exp_high = 0;
  logic prev_clk = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (clk_en) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexp_clk_en: at edge %0d", ecnt);
      end else begin
        e = sbq.pop_front();
        chk("en_cycle", ecnt, e.cyc);
        chk("en_mode", {30'd0, mode_act}, {30'd0, e.mode});
        exp_high = e.high;
      end
    end
    if (Clk_CPU && !prev_clk) begin
      chk("rise_with_en", {31'd0, clk_en}, 32'd1);
    end
    if (Clk_CPU) begin
      hcnt++;
    end else if (prev_clk) begin
      chk("high_len", hcnt, exp_high);
      hcnt = 0;
    end
    prev_clk = Clk_CPU;
  end

  int r;
  int r2;
  int exp_cc;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clk", {31'd0, Clk_CPU}, 32'd0);
    chk("rst_en", {31'd0, clk_en}, 32'd0);
    chk("rst_mode", {30'd0, mode_act}, 32'd0);
    chk("rst_cyc", cyc_cnt, 32'd0);
    r = ecnt;
    push(r + 2, 2'b00, 2);
    push(r + 6, 2'b00, 2);
    push(r + 10, 2'b00, 2);
    push(r + 17, 2'b10, 5);
    push(r + 27, 2'b10, 5);
    push(r + 35, 2'b01, 3);
    push(r + 41, 2'b01, 3);
    push(r + 47, 2'b11, 2);
    push(r + 71, 2'b11, 2);
    push(r + 79, 2'b11, 2);
    push(r + 90, 2'b10, 3);
    rst = 1'b0;

    wait_edge(r + 10);
    mode_sel = 2'b10;
    wait_edge(r + 11);
    chk("mode_pending", {30'd0, mode_act}, 32'd0);
    wait_edge(r + 12);
    chk("mode_applied", {30'd0, mode_act}, 32'd2);

    wait_edge(r + 27);
    mode_sel = 2'b01;
    wait_edge(r + 41);
    mode_sel = 2'b11;
    wait_edge(r + 44);
    chk("step_mode", {30'd0, mode_act}, 32'd3);
    chk("idle_low", {31'd0, Clk_CPU}, 32'd0);

    wait_edge(r + 46);
    step = 1'b1;
    wait_edge(r + 66);
    chk("held_low", {31'd0, Clk_CPU}, 32'd0);
    step = 1'b0;

    wait_edge(r + 70);
    step = 1'b1;
    wait_edge(r + 71);
    step = 1'b0;
    wait_edge(r + 72);
    step = 1'b1;
    wait_edge(r + 76);
    step = 1'b0;
    wait_edge(r + 78);
    step = 1'b1;
    wait_edge(r + 82);
    step = 1'b0;

    wait_edge(r + 84);
    mode_sel = 2'b10;
    wait_edge(r + 92);
    chk("pre_rst_high", {31'd0, Clk_CPU}, 32'd1);
    rst = 1'b1;
    wait_edge(r + 93);
    chk("mid_rst_clk", {31'd0, Clk_CPU}, 32'd0);
    chk("mid_rst_mode", {30'd0, mode_act}, 32'd0);
    chk("mid_rst_en", {31'd0, clk_en}, 32'd0);
    chk("mid_rst_cyc", cyc_cnt, 32'd0);
    mode_sel = 2'b00;
    rst = 1'b0;
    r2 = ecnt;
    for (int i = 0; i < 5; i++) begin
      push(r2 + 2 + 4 * i, 2'b00, 2);
    end

    wait_edge(r2 + 20);
`ifdef CLK_DIV_CYC_CNT_EN
    exp_cc = 5;
`else
    exp_cc = 0;
`endif
    chk("cyc_cnt", cyc_cnt, exp_cc);
    rst = 1'b1;
    wait_edge(r2 + 23);
    chk("cyc_cnt_rst", cyc_cnt, 32'd0);
    chk("queue_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: edge %0d", ecnt);
    $fatal(1, "timeout");
  end

endmodule
